// File: rtl/branch_unit_if.sv
// Resolve/predict/redirect bundle between EX, IF PC-select and the branch unit.
// master drives requests and observes results; slave is the branch unit itself.
interface branch_unit_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] pred_pc;
  logic                 pred_taken;
  logic                 res_valid;
  logic [3:0]           res_opcode;
  logic [WORD_SIZE-1:0] res_a;
  logic [WORD_SIZE-1:0] res_b;
  logic [WORD_SIZE-1:0] res_pc;
  logic [WORD_SIZE-1:0] res_pc_next;
  logic [WORD_SIZE-1:0] res_target;
  logic                 res_pred_taken;
  logic                 flush;
  logic                 out_valid;
  logic                 bcond;
  logic                 mispredict;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic [WORD_SIZE-1:0] br_count;
  logic [WORD_SIZE-1:0] mp_count;

  modport master (
    output pred_pc, res_valid, res_opcode, res_a, res_b, res_pc, res_pc_next,
           res_target, res_pred_taken, flush,
    input  pred_taken, out_valid, bcond, mispredict, redirect_pc, br_count, mp_count
  );

  modport slave (
    input  pred_pc, res_valid, res_opcode, res_a, res_b, res_pc, res_pc_next,
           res_target, res_pred_taken, flush,
    output pred_taken, out_valid, bcond, mispredict, redirect_pc, br_count, mp_count
  );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution with a direct-mapped 2-bit counter predictor, registered
// outcome/redirect, and saturating branch/mispredict statistics.
module branch_unit #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned BHT_DEPTH = 16
) (
  input logic          clk,
  input logic          reset,
  branch_unit_if.slave bus
);
  localparam int unsigned IDX_BITS = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;

  logic [1:0]          bht [BHT_DEPTH];
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic                cond_c;
  logic                is_branch_c;
  logic                accept_c;
  logic                mispred_c;
  logic [1:0]          ctr_cur;
  logic [1:0]          ctr_next;
  logic                unused_pc_bits;

  assign pred_idx       = bus.pred_pc[IDX_BITS-1:0];
  assign res_idx        = bus.res_pc[IDX_BITS-1:0];
  assign unused_pc_bits = ^{bus.pred_pc[WORD_SIZE-1:IDX_BITS], bus.res_pc[WORD_SIZE-1:IDX_BITS]};

  // No bypass: prediction always reflects the table before this cycle's update.
  assign bus.pred_taken = bht[pred_idx][1];

  // Branch condition evaluation; res_b only matters for the compare forms.
  always_comb begin
    cond_c      = 1'b0;
    is_branch_c = 1'b1;
    case (bus.res_opcode)
      OP_BNE:  cond_c = (bus.res_a != bus.res_b);
      OP_BEQ:  cond_c = (bus.res_a == bus.res_b);
      OP_BGZ:  cond_c = !bus.res_a[WORD_SIZE-1] && (bus.res_a != '0);
      OP_BLZ:  cond_c = bus.res_a[WORD_SIZE-1];
      default: is_branch_c = 1'b0;
    endcase
  end

  assign accept_c  = bus.res_valid && is_branch_c && !bus.flush;
  assign mispred_c = cond_c ^ bus.res_pred_taken;

  // Saturating move of the resolved entry toward the actual outcome.
  always_comb begin
    ctr_cur  = bht[res_idx];
    ctr_next = ctr_cur;
    if (cond_c) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[IDX_BITS'(i)] <= 2'b01;
      end
    end else if (accept_c) begin
      bht[res_idx] <= ctr_next;
    end
  end

  // Result registers hold their last value between accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.bcond       <= 1'b0;
      bus.mispredict  <= 1'b0;
      bus.redirect_pc <= '0;
      bus.br_count    <= '0;
      bus.mp_count    <= '0;
    end else begin
      bus.out_valid <= accept_c;
      if (accept_c) begin
        bus.bcond       <= cond_c;
        bus.mispredict  <= mispred_c;
        bus.redirect_pc <= cond_c ? bus.res_target : bus.res_pc_next;
        if (bus.br_count != '1) bus.br_count <= bus.br_count + WORD_SIZE'(1);
        if (mispred_c && (bus.mp_count != '1)) bus.mp_count <= bus.mp_count + WORD_SIZE'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_unit.sv
// Scoreboarded random and directed bench for branch_unit, plus small
// 32-bit and 4-bit instances for wide-operand, aliasing and saturation cases.
module tb_branch_unit;
  logic clk = 1'b0;
  logic rst16, rst32, rst4;
  always #5 clk = ~clk;

  branch_unit_if #(.WORD_SIZE(16)) i16 ();
  branch_unit_if #(.WORD_SIZE(32)) i32 ();
  branch_unit_if #(.WORD_SIZE(4))  i4  ();

  branch_unit #(.WORD_SIZE(16), .BHT_DEPTH(16)) u16 (.clk(clk), .reset(rst16), .bus(i16));
  branch_unit #(.WORD_SIZE(32), .BHT_DEPTH(4))  u32 (.clk(clk), .reset(rst32), .bus(i32));
  branch_unit #(.WORD_SIZE(4),  .BHT_DEPTH(2))  u4  (.clk(clk), .reset(rst4),  .bus(i4));

  typedef struct packed {
    logic        ov;
    logic        bc;
    logic        mp;
    logic [15:0] rpc;
    logic [15:0] br;
    logic [15:0] mpc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state for the 16-bit instance
  int          m_ctr [16];
  logic        m_init = 1'b0;
  logic        m_ov, m_bc, m_mp;
  logic [15:0] m_rpc, m_br, m_mpc;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // One cycle of 16-bit stimulus; model advances and pushes the expected result.
  task automatic step16(input logic rst, input logic rv, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] pc,
                        input logic [15:0] nx, input logic [15:0] tg, input logic pt,
                        input logic fl, input logic [15:0] ppc);
    logic tk;
    logic acc;
    int   k;
    @(negedge clk);
    rst16 = rst;
    i16.res_valid = rv; i16.res_opcode = op; i16.res_a = a; i16.res_b = b;
    i16.res_pc = pc; i16.res_pc_next = nx; i16.res_target = tg;
    i16.res_pred_taken = pt; i16.flush = fl; i16.pred_pc = ppc;
    #1;
    if (m_init && !rst) chk("pred_taken", 32'(i16.pred_taken), 32'(m_ctr[ppc % 16] >= 2));
    if (rst) begin
      m_init = 1'b1;
      foreach (m_ctr[i]) m_ctr[i] = 1;
      m_ov = 0; m_bc = 0; m_mp = 0; m_rpc = 0; m_br = 0; m_mpc = 0;
    end else begin
      case (op)
        4'd0:    tk = (a != b);
        4'd1:    tk = (a == b);
        4'd2:    tk = ($signed(a) > 0);
        4'd3:    tk = ($signed(a) < 0);
        default: tk = 1'b0;
      endcase
      acc  = rv && (op < 4) && !fl;
      m_ov = acc;
      if (acc) begin
        m_bc  = tk;
        m_mp  = (tk != pt);
        m_rpc = tk ? tg : nx;
        if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
        if (m_mp && m_mpc != 16'hFFFF) m_mpc = m_mpc + 16'd1;
        k = pc % 16;
        if (tk && m_ctr[k] < 3) m_ctr[k]++;
        else if (!tk && m_ctr[k] > 0) m_ctr[k]--;
      end
    end
    sb.push_back('{m_ov, m_bc, m_mp, m_rpc, m_br, m_mpc});
  endtask

  task automatic idle16(input logic [15:0] ppc);
    step16(0, 0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0, ppc);
  endtask

  // Monitor: compares the registered outputs after each edge with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid",   32'(i16.out_valid),  32'(e.ov));
        chk("bcond",       32'(i16.bcond),      32'(e.bc));
        chk("mispredict",  32'(i16.mispredict), 32'(e.mp));
        chk("redirect_pc", 32'(i16.redirect_pc), 32'(e.rpc));
        chk("br_count",    32'(i16.br_count),   32'(e.br));
        chk("mp_count",    32'(i16.mp_count),   32'(e.mpc));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  rop;
    rst16 = 1; rst32 = 1; rst4 = 1;
    i16.res_valid = 0; i16.res_opcode = 0; i16.res_a = 0; i16.res_b = 0; i16.res_pc = 0;
    i16.res_pc_next = 0; i16.res_target = 0; i16.res_pred_taken = 0; i16.flush = 0; i16.pred_pc = 0;
    i32.res_valid = 0; i32.res_opcode = 0; i32.res_a = 0; i32.res_b = 0; i32.res_pc = 0;
    i32.res_pc_next = 0; i32.res_target = 0; i32.res_pred_taken = 0; i32.flush = 0; i32.pred_pc = 0;
    i4.res_valid = 0; i4.res_opcode = 0; i4.res_a = 0; i4.res_b = 0; i4.res_pc = 0;
    i4.res_pc_next = 0; i4.res_target = 0; i4.res_pred_taken = 0; i4.flush = 0; i4.pred_pc = 0;

    // Reset with a resolve presented: it must be discarded
    step16(1, 1, 4'd1, 16'd5, 16'd5, 16'h10, 16'h11, 16'h40, 0, 0, 16'h0);
    step16(1, 0, 4'd0, 16'd0, 16'd0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0);
    for (int i = 0; i < 16; i++) idle16(16'(i));

    // BEQ taken, mispredicted; entry 0 goes weak-T
    step16(0, 1, 4'd1, 16'd5, 16'd5, 16'h0010, 16'h0011, 16'h0040, 0, 0, 16'h0010);
    idle16(16'h0010);

    // BGZ/BLZ sign cases back-to-back
    step16(0, 1, 4'd2, 16'h0000, 16'h1234, 16'h0020, 16'h0021, 16'h0100, 0, 0, 16'h0020);
    step16(0, 1, 4'd2, 16'h8000, 16'h0000, 16'h0021, 16'h0022, 16'h0101, 0, 0, 16'h0021);
    step16(0, 1, 4'd2, 16'h0001, 16'hFFFF, 16'h0022, 16'h0023, 16'h0102, 0, 0, 16'h0022);
    step16(0, 1, 4'd3, 16'hFFFF, 16'h0000, 16'h0023, 16'h0024, 16'h0103, 0, 0, 16'h0023);
    step16(0, 1, 4'd3, 16'h0000, 16'h0000, 16'h0024, 16'h0025, 16'h0104, 0, 0, 16'h0024);

    // Same index: taken x3, not-taken x1, predicting that index every cycle
    for (int i = 0; i < 3; i++)
      step16(0, 1, 4'd1, 16'd7, 16'd7, 16'h0033, 16'h0034, 16'h0200, 1, 0, 16'h0033);
    step16(0, 1, 4'd0, 16'd7, 16'd7, 16'h0033, 16'h0034, 16'h0200, 1, 0, 16'h0033);
    idle16(16'h0033);

    // Flushed resolve and non-branch opcode are both ignored
    step16(0, 1, 4'd1, 16'd1, 16'd1, 16'h0033, 16'h0034, 16'h0300, 0, 1, 16'h0033);
    step16(0, 1, 4'hF, 16'd1, 16'd1, 16'h0033, 16'h0034, 16'h0300, 0, 0, 16'h0033);
    idle16(16'h0033);

    // Randomized traffic, including occasional mid-stream reset
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: ra = 16'h0000;
        1: ra = 16'h8000;
        2: ra = 16'hFFFF;
        3: ra = 16'h0001;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 1) == 1) ? ra : 16'($urandom);
      rop = ($urandom_range(0, 5) > 3) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      step16(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), rop, ra, rb,
             16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0), 16'($urandom));
    end
    idle16(16'h0);
    @(negedge clk);

    // 32-bit, 4-entry instance: bit-31 BNE, aliasing, signed BGZ
    rst32 = 1;
    @(negedge clk);
    rst32 = 0;
    i32.res_valid = 1; i32.res_opcode = 4'd0; i32.res_a = 32'h8000_0000; i32.res_b = 32'h0;
    i32.res_pc = 32'h5; i32.res_pc_next = 32'h6; i32.res_target = 32'hDEAD_BEEF; i32.res_pred_taken = 0;
    @(negedge clk);
    i32.res_valid = 0; i32.pred_pc = 32'h1;
    #1;
    chk("w32_out_valid",  32'(i32.out_valid), 32'd1);
    chk("w32_bcond",      32'(i32.bcond), 32'd1);
    chk("w32_mispredict", 32'(i32.mispredict), 32'd1);
    chk("w32_redirect",   i32.redirect_pc, 32'hDEAD_BEEF);
    chk("w32_br_count",   i32.br_count, 32'd1);
    chk("w32_alias_pred", 32'(i32.pred_taken), 32'd1);
    i32.pred_pc = 32'h2;
    #1;
    chk("w32_other_pred", 32'(i32.pred_taken), 32'd0);
    @(negedge clk);
    i32.res_valid = 1; i32.res_a = 32'h1234_5678; i32.res_b = 32'h1234_5678;
    i32.res_pc = 32'h100; i32.res_pc_next = 32'h101; i32.res_target = 32'h200; i32.res_pred_taken = 1;
    @(negedge clk);
    chk("w32_bne_eq_bcond", 32'(i32.bcond), 32'd0);
    chk("w32_bne_redirect", i32.redirect_pc, 32'h101);
    chk("w32_mp_count",     i32.mp_count, 32'd2);
    i32.res_opcode = 4'd2; i32.res_a = 32'h8000_0000; i32.res_pred_taken = 0;
    @(negedge clk);
    i32.res_valid = 0;
    chk("w32_bgz_neg", 32'(i32.bcond), 32'd0);
    chk("w32_br_count3", i32.br_count, 32'd3);

    // 4-bit instance: counters saturate at all-ones
    rst4 = 1;
    @(negedge clk);
    rst4 = 0;
    i4.res_valid = 1; i4.res_opcode = 4'd1; i4.res_a = 4'd0; i4.res_b = 4'd0;
    i4.res_pc = 4'd0; i4.res_pc_next = 4'd1; i4.res_target = 4'd9; i4.res_pred_taken = 0;
    repeat (20) @(negedge clk);
    i4.res_valid = 0; i4.pred_pc = 4'd0;
    #1;
    chk("sat_br_count",  32'(i4.br_count), 32'd15);
    chk("sat_mp_count",  32'(i4.mp_count), 32'd15);
    chk("sat_pred",      32'(i4.pred_taken), 32'd1);
    @(negedge clk);
    chk("sat_out_valid", 32'(i4.out_valid), 32'd0);
    chk("sat_br_hold",   32'(i4.br_count), 32'd15);
    chk("sat_redirect",  32'(i4.redirect_pc), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
